// File: rtl/dma_rd_arbiter.sv
// dma_rd_arbiter: shares one burst read channel between two masters.
// Define DMA_RD_ARB_FIXED_PRIO_EN to let master 1 win ties instead of round-robin.
module dma_rd_arbiter (
  input  logic        clk,
  input  logic        rst,
  input  logic [63:0] m_req_addr,
  input  logic [9:0]  m_req_len,
  input  logic [1:0]  m_req_valid,
  output logic [1:0]  m_req_ready,
  output logic [31:0] m_rdata,
  output logic        m_rlast,
  output logic [1:0]  m_rvalid,
  input  logic [1:0]  m_rready,
  output logic [31:0] rd_req_addr,
  output logic [4:0]  rd_req_len,
  output logic        rd_req_valid,
  input  logic        rd_req_ready,
  input  logic [31:0] rd_rdata,
  input  logic        rd_last,
  input  logic        rd_valid,
  output logic        rd_ready,
  output logic        grant,
  output logic        busy,
  output logic        err
);

  typedef enum logic [2:0] {
    IDLE = 3'b001,
    REQ  = 3'b010,
    DATA = 3'b100
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [4:0]  len_q, len_d;
  logic [4:0]  beat_cnt_q, beat_cnt_d;
  logic        grant_q, grant_d;
  logic        last_grant_q, last_grant_d;
  logic        err_q, err_d;

  logic        any_req;
  logic        winner;
  logic        beat_hs;
  logic        len_hit;

  always_comb begin
    any_req = |m_req_valid;
    if (m_req_valid == 2'b11) begin
`ifdef DMA_RD_ARB_FIXED_PRIO_EN
      winner = 1'b1;
`else
      winner = ~last_grant_q;
`endif
    end else begin
      winner = m_req_valid[1];
    end
  end

  assign beat_hs = rd_valid && m_rready[grant_q];
  assign len_hit = (beat_cnt_q == len_q);

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    len_d        = len_q;
    beat_cnt_d   = beat_cnt_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    err_d        = err_q;
    m_req_ready  = 2'b00;
    m_rvalid     = 2'b00;
    m_rlast      = 1'b0;
    rd_req_valid = 1'b0;
    rd_ready     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (any_req) begin
          m_req_ready[winner] = 1'b1;
          addr_d       = winner ? m_req_addr[63:32] : m_req_addr[31:0];
          len_d        = winner ? m_req_len[9:5] : m_req_len[4:0];
          grant_d      = winner;
          last_grant_d = winner;
          state_d      = REQ;
        end
      end
      REQ: begin
        rd_req_valid = 1'b1;
        if (rd_req_ready) begin
          beat_cnt_d = 5'd0;
          state_d    = DATA;
        end
      end
      DATA: begin
        rd_ready          = m_rready[grant_q];
        m_rvalid[grant_q] = rd_valid;
        m_rlast           = rd_last;
        if (beat_hs) begin
          beat_cnt_d = beat_cnt_q + 5'd1;
          // last flag must coincide exactly with the latched length
          if (rd_last != len_hit) err_d = 1'b1;
          if (rd_last) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      addr_q       <= 32'd0;
      len_q        <= 5'd0;
      beat_cnt_q   <= 5'd0;
      grant_q      <= 1'b0;
      last_grant_q <= 1'b1;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      len_q        <= len_d;
      beat_cnt_q   <= beat_cnt_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      err_q        <= err_d;
    end
  end

  assign m_rdata     = rd_rdata;
  assign rd_req_addr = addr_q;
  assign rd_req_len  = len_q;
  assign grant       = grant_q;
  assign busy        = (state_q != IDLE);
  assign err         = err_q;

endmodule

// File: tb/tb_dma_rd_arbiter.sv
// Directed self-checking bench for dma_rd_arbiter.
module tb_dma_rd_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [63:0] m_req_addr;
  logic [9:0]  m_req_len;
  logic [1:0]  m_req_valid;
  logic [1:0]  m_req_ready;
  logic [31:0] m_rdata;
  logic        m_rlast;
  logic [1:0]  m_rvalid;
  logic [1:0]  m_rready;
  logic [31:0] rd_req_addr;
  logic [4:0]  rd_req_len;
  logic        rd_req_valid;
  logic        rd_req_ready;
  logic [31:0] rd_rdata;
  logic        rd_last;
  logic        rd_valid;
  logic        rd_ready;
  logic        grant;
  logic        busy;
  logic        err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  dma_rd_arbiter dut (
    .clk(clk), .rst(rst),
    .m_req_addr(m_req_addr), .m_req_len(m_req_len),
    .m_req_valid(m_req_valid), .m_req_ready(m_req_ready),
    .m_rdata(m_rdata), .m_rlast(m_rlast),
    .m_rvalid(m_rvalid), .m_rready(m_rready),
    .rd_req_addr(rd_req_addr), .rd_req_len(rd_req_len),
    .rd_req_valid(rd_req_valid), .rd_req_ready(rd_req_ready),
    .rd_rdata(rd_rdata), .rd_last(rd_last),
    .rd_valid(rd_valid), .rd_ready(rd_ready),
    .grant(grant), .busy(busy), .err(err)
  );

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic accept(input int m, input logic [31:0] a,
                        input logic [4:0] l);
    logic [1:0] exp_rdy;
    exp_rdy = 2'b00;
    exp_rdy[m] = 1'b1;
    if (m == 1) begin
      m_req_addr[63:32] = a;
      m_req_len[9:5]    = l;
    end else begin
      m_req_addr[31:0] = a;
      m_req_len[4:0]   = l;
    end
    m_req_valid[m] = 1'b1;
    #2 chk("req_ready", m_req_ready, exp_rdy);
    chk("idle_busy", busy, 1'b0);
    step();
    m_req_valid[m] = 1'b0;
  endtask

  task automatic mem_req(input int m, input logic [31:0] a,
                         input logic [4:0] l);
    #2 chk("rd_req_valid", rd_req_valid, 1'b1);
    chk("rd_req_addr", rd_req_addr, a);
    chk("rd_req_len", rd_req_len, l);
    chk("grant", grant, m[0]);
    chk("busy", busy, 1'b1);
    chk("req_ready_req", m_req_ready, 2'b00);
    step();
    chk("req_stall_valid", rd_req_valid, 1'b1);
    chk("req_stall_addr", rd_req_addr, a);
    rd_req_ready = 1'b1;
    step();
    rd_req_ready = 1'b0;
    #2 chk("req_done", rd_req_valid, 1'b0);
  endtask

  task automatic run_data(input int m, input int nbeats, input bit bp,
                          input int stop);
    int k;
    logic rdy;
    logic [1:0] exp_v;
    k = 0;
    exp_v = 2'b00;
    exp_v[m] = 1'b1;
    for (int cyc = 0; cyc < 40 && k < stop; cyc++) begin
      rdy = bp ? (cyc % 2 == 0) : 1'b1;
      m_rready = 2'b11;
      m_rready[m] = rdy;
      rd_valid = 1'b1;
      rd_rdata = 32'hD000_0000 + k;
      rd_last  = (k == nbeats - 1);
      #2 chk("rd_ready", rd_ready, rdy);
      chk("m_rvalid", m_rvalid, exp_v);
      chk("m_rdata", m_rdata, 32'hD000_0000 + k);
      chk("m_rlast", m_rlast, (k == nbeats - 1));
      chk("req_ready_data", m_req_ready, 2'b00);
      if (rdy) k++;
      step();
    end
    chk("beats", k, stop);
    if (stop == nbeats) begin
      rd_valid = 1'b0;
      rd_last  = 1'b0;
      #2 chk("idle_after_last", busy, 1'b0);
    end
  endtask

  initial begin
    int first;
    int second;
`ifdef DMA_RD_ARB_FIXED_PRIO_EN
    first = 1;
`else
    first = 0;
`endif
    second = 1 - first;

    rst = 1'b1;
    m_req_addr = 64'd0;
    m_req_len = 10'd0;
    m_req_valid = 2'b00;
    m_rready = 2'b00;
    rd_req_ready = 1'b0;
    rd_rdata = 32'h1234_5678;
    rd_last = 1'b1;
    rd_valid = 1'b1;
    #12;
    chk("rst_req_ready", m_req_ready, 2'b00);
    chk("rst_m_rvalid", m_rvalid, 2'b00);
    chk("rst_rd_req_valid", rd_req_valid, 1'b0);
    chk("rst_rd_ready", rd_ready, 1'b0);
    chk("rst_addr", rd_req_addr, 32'd0);
    chk("rst_len", rd_req_len, 5'd0);
    chk("rst_grant", grant, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_err", err, 1'b0);
    chk("rst_rlast", m_rlast, 1'b0);
    chk("rst_rdata", m_rdata, 32'h1234_5678);
    rd_valid = 1'b0;
    rd_last = 1'b0;
    rst = 1'b0;
    step();

    // tie from reset
    m_req_addr = {32'h0000_3000, 32'h0000_2000};
    m_req_len = {5'd1, 5'd1};
    m_req_valid = 2'b11;
    accept(first, first ? 32'h3000 : 32'h2000, 5'd1);
    mem_req(first, first ? 32'h3000 : 32'h2000, 5'd1);
    run_data(first, 2, 1'b0, 2);
    accept(second, second ? 32'h3000 : 32'h2000, 5'd1);
    mem_req(second, second ? 32'h3000 : 32'h2000, 5'd1);
    run_data(second, 2, 1'b0, 2);
    chk("tie_err", err, 1'b0);

    // single master, 8 beats
    accept(0, 32'h1000, 5'd7);
    mem_req(0, 32'h1000, 5'd7);
    run_data(0, 8, 1'b0, 8);
    chk("single_err", err, 1'b0);

    // backpressure on master 1
    accept(1, 32'h4000, 5'd3);
    mem_req(1, 32'h4000, 5'd3);
    run_data(1, 4, 1'b1, 4);
    chk("bp_err", err, 1'b0);

    // early rd_last
    accept(0, 32'h5000, 5'd3);
    mem_req(0, 32'h5000, 5'd3);
    run_data(0, 2, 1'b0, 2);
    chk("mismatch_err", err, 1'b1);
    accept(1, 32'h6000, 5'd0);
    mem_req(1, 32'h6000, 5'd0);
    run_data(1, 1, 1'b0, 1);
    chk("err_sticky", err, 1'b1);

    // reset in the middle of a burst
    accept(0, 32'h7000, 5'd7);
    mem_req(0, 32'h7000, 5'd7);
    run_data(0, 8, 1'b0, 2);
    rst = 1'b1;
    #1;
    chk("mid_busy", busy, 1'b0);
    chk("mid_rd_ready", rd_ready, 1'b0);
    chk("mid_m_rvalid", m_rvalid, 2'b00);
    chk("mid_grant", grant, 1'b0);
    chk("mid_err", err, 1'b0);
    chk("mid_rlast", m_rlast, 1'b0);
    rst = 1'b0;
    rd_valid = 1'b0;
    rd_last = 1'b0;
    step();
    accept(1, 32'h8000, 5'd1);
    mem_req(1, 32'h8000, 5'd1);
    run_data(1, 2, 1'b0, 2);
    chk("post_rst_err", err, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dma_rd_arbiter.md
# dma_rd_arbiter

Two-master read-port arbiter that shares the single burst-capable memory read channel between master 0 (CPU-side fetch path) and master 1 (DMA engine read side). It sits between the requesters and the memory read interface. Each accepted request is registered, forwarded as one burst, and owned exclusively by its master until the memory's last beat is handshaked. Grant is round-robin by default, with a compile-time fixed-priority option.

## Interface
- No parameters. Data width is 32, burst length field is 5 bits (beats = len+1).
- `clk` in 1: single clock, all logic on rising edge.
- `rst` in 1: reset, asynchronous, active-high.
- `m_req_addr` in 64: {m1, m0} request addresses.
- `m_req_len` in 10: {m1, m0} burst lengths.
- `m_req_valid` in 2: per-master request valid.
- `m_req_ready` out 2: per-master request accept.
- `m_rdata` out 32: read data, broadcast to both masters.
- `m_rlast` out 1: last-beat flag, broadcast.
- `m_rvalid` out 2: per-master data valid. Only the granted bit can be 1.
- `m_rready` in 2: per-master data ready.
- `rd_req_addr` out 32, `rd_req_len` out 5, `rd_req_valid` out 1, `rd_req_ready` in 1: memory request channel.
- `rd_rdata` in 32, `rd_last` in 1, `rd_valid` in 1, `rd_ready` out 1: memory data channel.
- `grant` out 1: index of the current or last owner.
- `busy` out 1: high when the FSM is not in IDLE.
- `err` out 1: sticky burst-length mismatch flag.

## Operation
- FSM states are IDLE, REQ and DATA, one-hot encoded. Reset state is IDLE.
- **IDLE**
  - If any `m_req_valid` bit is set, select a winner.
  - Assert `m_req_ready[winner]` for that cycle, combinationally.
  - Latch the winner's addr and len, and set `grant` to the winner.
  - Move to REQ.
- **Winner selection**
  - Only one master valid: that master wins.
  - Both masters valid: winner = ~`last_grant`.
  - `last_grant` updates to the winner at acceptance. Its reset value is 1, so master 0 wins the first tie.
- **REQ**
  - `rd_req_valid` = 1 and `rd_req_addr`/`rd_req_len` are driven from the latched values.
  - Stay in REQ until `rd_req_valid && rd_req_ready`. Then clear `beat_cnt` (5-bit) to 0 and move to DATA.
- **DATA**
  - `rd_ready` = `m_rready[grant]`.
  - `m_rvalid[grant]` = `rd_valid`; the other bit is 0.
  - `m_rdata` = `rd_rdata` and `m_rlast` = `rd_last`, both pass-through.
  - Each handshake (`rd_valid && rd_ready`) increments `beat_cnt`.
  - A handshake with `rd_last` = 1 moves the FSM to IDLE.
- **Error detection**
  - `err` sets if a handshake has `rd_last` = 1 with `beat_cnt` != latched len.
  - `err` also sets if a handshake has `rd_last` = 0 with `beat_cnt` == latched len.
  - The burst still terminates only on `rd_last`. `err` clears only on `rst`.
- `m_req_ready` is 0 for both masters in REQ and DATA. A non-granted master simply holds `valid`.

## Timing
- **Reset values:**
  - `m_req_ready`=0, `m_rvalid`=0, `rd_req_valid`=0, `rd_ready`=0, `rd_req_addr`=0, `rd_req_len`=0.
  - `grant`=0, `busy`=0, `err`=0, `m_rlast`=0.
  - `m_rdata` follows `rd_rdata`.
- **Request latency:** a master handshake in cycle T drives `rd_req_valid` high in T+1.
- **Data path:** zero latency; `rd_*` to `m_*` is purely combinational.
- **Back-to-back bursts:** after the last beat in cycle T, the FSM is in IDLE in T+1. The next acceptance occurs in T+1 and its memory request appears in T+2. The minimum gap is one idle cycle.
- **Same-cycle requests:** if both masters assert valid in the same cycle, the round-robin rule decides. A new request arriving during DATA is never accepted before the IDLE cycle.
- **Reset mid-operation:** asynchronous return to IDLE, and all outputs take their reset values immediately. Any in-flight memory burst is abandoned; the memory side is reset by the same `rst`.
- **Stale request channel:** `rd_req_valid` stays high until `rd_req_ready`. The addr and len are stable for the entire REQ state.

## Configuration
- `DMA_RD_ARB_FIXED_PRIO_EN`
  - **Defined:** master 1 (DMA) always wins when both are valid. `last_grant` is still tracked but ignored.
  - **Undefined:** round-robin as specified above.
  - Everything else is identical in both builds.

## Test plan
- **Single master:** m0 requests addr 0x1000, len 7; memory returns 8 beats with `rd_last` on beat 8 -> `rd_req_addr`=0x1000, `rd_req_len`=7, 8 beats on `m_rvalid[0]`, `err`=0, IDLE after the last beat.
- **Tie from reset:** m0 and m1 assert in the same cycle -> m0 granted first, m1 next with one idle cycle between bursts. With `DMA_RD_ARB_FIXED_PRIO_EN`, m1 is granted first.
- **Backpressure:** `m_rready[1]` toggles 1,0,1,0 during a len-3 burst -> `rd_ready` mirrors it, exactly 4 handshakes, no beat lost or duplicated.
- **Length mismatch:** len=3 request, `rd_last` on beat 2 -> `err`=1 and sticky, FSM returns to IDLE. The next clean burst leaves `err`=1.
- **Reset in DATA:** pulse `rst` after beat 2 of 8 -> same-cycle `busy`=0, `rd_ready`=0, `m_rvalid`=0, `grant`=0. A later m1 request is served normally.
